jk_reg_arbiter: RTL and testbench

JK_REG_ARBITER -- requirements
Module: jk_reg_arbiter

---
 rtl/jk_reg_arbiter_pkg.sv | 27 ++
 rtl/ffd.sv | 27 ++
 rtl/jk_reg_arbiter.sv | 107 ++++++++++
 tb/tb_jk_reg_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/jk_reg_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_reg_arbiter_pkg
// Brief    : Shared op and state encodings for the JK register arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package jk_reg_arbiter_pkg;

  localparam logic [1:0] C_OP_LOAD   = 2'b00;
  localparam logic [1:0] C_OP_SET    = 2'b01;
  localparam logic [1:0] C_OP_CLEAR  = 2'b10;
  localparam logic [1:0] C_OP_TOGGLE = 2'b11;

  localparam logic [1:0] C_ST_INIT  = 2'd0;
  localparam logic [1:0] C_ST_IDLE  = 2'd1;
  localparam logic [1:0] C_ST_APPLY = 2'd2;
  localparam logic [1:0] C_ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_INIT  = C_ST_INIT,
    ST_IDLE  = C_ST_IDLE,
    ST_APPLY = C_ST_APPLY,
    ST_DONE  = C_ST_DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ffd.sv
`default_nettype none
// ============================================================================
// Module   : ffd
// Brief    : JK flip-flop cell (no reset; cleared through j/k by its user).
// Revision : 1.0 - initial release
// ============================================================================
module ffd (
  input  logic j,
  input  logic k,
  input  logic clk,
  output logic q,
  output logic q_barra
);

  always_ff @(posedge clk) begin
    case ({j, k})
      2'b01:   q <= 1'b0;
      2'b10:   q <= 1'b1;
      2'b11:   q <= ~q;
      default: q <= q;
    endcase
  end

  assign q_barra = ~q;

endmodule
`default_nettype wire

// File: rtl/jk_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : jk_reg_arbiter
// Brief    : Two-requester round-robin arbiter driving a JK flip-flop bank.
// Revision : 1.0 - initial release
// ============================================================================
module jk_reg_arbiter
  import jk_reg_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] data0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       gnt,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] q
);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_last;
  logic             r_win;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic             w_win;
  logic             w_take;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_qb_unused;

  // On a tie the requester not granted last wins; otherwise the sole requester.
  assign w_win  = (req == 2'b11) ? ~r_last : req[1];
  assign w_take = (r_state == ST_IDLE) && (|req);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (w_take) begin
        r_last <= w_win;
        r_win  <= w_win;
        r_op   <= w_win ? op1 : op0;
        r_data <= w_win ? data1 : data0;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    gnt          = 2'b00;
    done         = 1'b0;
    busy         = 1'b1;
    w_j          = '0;
    w_k          = '0;
    case (r_state)
      ST_INIT: begin
        w_k          = '1;
        w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        busy = 1'b0;
        if (|req) w_state_next = ST_APPLY;
      end
      ST_APPLY: begin
        gnt = r_win ? 2'b10 : 2'b01;
        case (r_op)
          C_OP_LOAD: begin
            w_j = r_data;
            w_k = ~r_data;
          end
          C_OP_SET:   w_j = r_data;
          C_OP_CLEAR: w_k = r_data;
          default: begin
            w_j = r_data;
            w_k = r_data;
          end
        endcase
        w_state_next = ST_DONE;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_INIT;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    ffd u_ffd (
      .j       (w_j[i]),
      .k       (w_k[i]),
      .clk     (clk),
      .q       (q[i]),
      .q_barra (w_qb_unused[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_jk_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_reg_arbiter
// Brief    : Directed plus randomized checks of jk_reg_arbiter against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_reg_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [1:0] op0;
  logic [1:0] op1;
  logic [7:0] data0;
  logic [7:0] data1;
  logic [1:0] gnt;
  logic       done;
  logic       busy;
  logic [7:0] q;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] m_bank;
  int         m_last;

  jk_reg_arbiter #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .op0   (op0),
    .data0 (data0),
    .op1   (op1),
    .data1 (data1),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .q     (q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] apply_op(input logic [7:0] b, input logic [1:0] op,
                                          input logic [7:0] d);
    case (op)
      2'b00:   return d;
      2'b01:   return b | d;
      2'b10:   return b & ~d;
      default: return b ^ d;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction starting in IDLE; jd0 is driven on data0 during APPLY.
  task automatic txn(input logic [1:0] r, input logic [1:0] o0, input logic [7:0] d0,
                     input logic [1:0] o1, input logic [7:0] d1, input logic [7:0] jd0,
                     output int gcyc);
    int w;
    req = r; op0 = o0; data0 = d0; op1 = o1; data1 = d1;
    w = (r == 2'b11) ? 1 - m_last : (r[1] ? 1 : 0);
    m_last = w;
    m_bank = apply_op(m_bank, (w == 1) ? o1 : o0, (w == 1) ? d1 : d0);
    tick;
    gcyc = cyc;
    chk("apply_gnt", {30'd0, gnt}, (w == 1) ? 32'd2 : 32'd1);
    chk("apply_done", {31'd0, done}, 32'd0);
    chk("apply_busy", {31'd0, busy}, 32'd1);
    req = 2'($urandom); op0 = 2'($urandom); op1 = 2'($urandom);
    data0 = jd0; data1 = 8'($urandom);
    tick;
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("done_gnt", {30'd0, gnt}, 32'd0);
    chk("done_q", {24'd0, q}, {24'd0, m_bank});
    req = 2'($urandom); data0 = 8'($urandom); data1 = 8'($urandom);
    tick;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_q", {24'd0, q}, {24'd0, m_bank});
    req = 2'b00;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req   = 2'b00;
    tick;
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    tick;
    chk("rst_q", {24'd0, q}, 32'd0);
    chk("rst_idle_busy", {31'd0, busy}, 32'd0);
    chk("rst_idle_gnt", {30'd0, gnt}, 32'd0);
    m_bank = 8'h00;
    m_last = 1;
  endtask

  initial begin
    int g1, g2, g3;
    reset = 1'b1; req = 2'b00; op0 = 2'b00; op1 = 2'b00; data0 = 8'h00; data1 = 8'h00;

    do_reset();
    tick;
    chk("idle_hold_busy", {31'd0, busy}, 32'd0);

    // Single LOAD then SET / CLEAR / TOGGLE
    txn(2'b01, 2'b00, 8'hA5, 2'b00, 8'h00, 8'h5A, g1);
    chk("load_A5", {24'd0, q}, 32'hA5);
    txn(2'b01, 2'b01, 8'h0F, 2'b00, 8'h00, 8'h00, g1);
    chk("set_AF", {24'd0, q}, 32'hAF);
    txn(2'b01, 2'b10, 8'hF0, 2'b00, 8'h00, 8'h00, g1);
    chk("clear_0F", {24'd0, q}, 32'h0F);
    txn(2'b01, 2'b11, 8'hFF, 2'b00, 8'h00, 8'h00, g1);
    chk("toggle_F0", {24'd0, q}, 32'hF0);

    // Held simultaneous requests right after reset alternate 01, 10, 01
    do_reset();
    txn(2'b11, 2'b00, 8'h12, 2'b00, 8'h34, 8'h00, g1);
    chk("rr_first", {24'd0, q}, 32'h12);
    txn(2'b11, 2'b00, 8'h12, 2'b00, 8'h34, 8'h00, g2);
    chk("rr_second", {24'd0, q}, 32'h34);
    txn(2'b11, 2'b00, 8'h12, 2'b00, 8'h34, 8'h00, g3);
    chk("rr_third", {24'd0, q}, 32'h12);
    chk("rr_spacing1", g2 - g1, 32'd3);
    chk("rr_spacing2", g3 - g2, 32'd3);

    // Reset during the APPLY cycle of a TOGGLE
    txn(2'b01, 2'b00, 8'h3C, 2'b00, 8'h00, 8'h00, g1);
    req = 2'b01; op0 = 2'b11; data0 = 8'hFF;
    tick;
    chk("abort_gnt", {30'd0, gnt}, 32'd1);
    reset = 1'b1; req = 2'b00;
    tick;
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    tick;
    chk("abort_q", {24'd0, q}, 32'd0);
    chk("abort_nodone", {31'd0, done}, 32'd0);
    m_bank = 8'h00; m_last = 1;
    txn(2'b11, 2'b00, 8'h66, 2'b00, 8'h99, 8'h00, g1);
    chk("abort_next_r0", {24'd0, q}, 32'h66);

    // Reset held for several cycles keeps INIT and a clear bank
    reset = 1'b1;
    tick; tick; tick;
    chk("hold_rst_busy", {31'd0, busy}, 32'd1);
    chk("hold_rst_q", {24'd0, q}, 32'd0);
    reset = 1'b0;
    tick;
    m_bank = 8'h00; m_last = 1;

    // Operand change during APPLY is ignored
    txn(2'b01, 2'b00, 8'h11, 2'b00, 8'h00, 8'h22, g1);
    chk("capture_11", {24'd0, q}, 32'h11);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(3) == 0) begin
        req = 2'b00; op0 = 2'($urandom); data0 = 8'($urandom); data1 = 8'($urandom);
        tick;
        chk("rnd_idle_busy", {31'd0, busy}, 32'd0);
        chk("rnd_idle_q", {24'd0, q}, {24'd0, m_bank});
      end else begin
        txn(2'($urandom_range(3, 1)), 2'($urandom), 8'($urandom),
            2'($urandom), 8'($urandom), 8'($urandom), g1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
